paralelo_serial: RTL and testbench

- Transmit-side parallel-to-serial converter for the PHY TX path, the counterpart of the RX serial-to-parallel block.
- Accepts 8-bit bytes from the upstream byte-rate logic and serialises them MSB first on a single bit line at clk_32f, with 8 bit-cycles per symbol.
- After reset it sends SYNC_COUNT comma symbols (0xBC) so the receiver can align and assert its active flag.
- It then sends user bytes when offered, and sends the comma as idle filler otherwise.

---
 rtl/paralelo_serial_if.sv | 28 ++
 rtl/paralelo_serial.sv | 79 +++++++
 tb/tb_paralelo_serial.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/paralelo_serial_if.sv
// Byte-side handshake and serial-side outputs of the TX parallel-to-serial converter.
// The master drives bytes in; the slave (the converter) drives the serial line and status.
interface paralelo_serial_if;
  logic [7:0] data_input;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       symbol_start;
  logic       active_out;

  modport master (
    output data_input,
    output valid_in,
    input  ready_out,
    input  data_out,
    input  symbol_start,
    input  active_out
  );

  modport slave (
    input  data_input,
    input  valid_in,
    output ready_out,
    output data_out,
    output symbol_start,
    output active_out
  );
endinterface

// File: rtl/paralelo_serial.sv
// TX parallel-to-serial converter: sends SYNC_COUNT commas after reset, then user bytes
// (or comma filler) MSB first, one 8-bit symbol per 8 clk_32f cycles.
module paralelo_serial #(
  parameter int         SYNC_COUNT = 4,
  parameter logic [7:0] IDLE_CHAR  = 8'hBC
) (
  input  logic               clk_32f,
  input  logic               reset,
  paralelo_serial_if.slave   bus
);

  typedef enum logic {SYNC, ACTIVE} state_t;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT);

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic [7:0] sym_reg, sym_next;
  logic [3:0] sync_cnt_reg, sync_cnt_next;
  logic       data_out_reg, data_out_next;
  logic       symbol_start_reg, symbol_start_next;
  logic       ready_out_reg, ready_out_next;
  logic       active_out_reg, active_out_next;
  logic       load_active;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_reg        <= SYNC;
      cnt_reg          <= 3'd0;
      sym_reg          <= IDLE_CHAR;
      sync_cnt_reg     <= 4'd1;
      data_out_reg     <= 1'b0;
      symbol_start_reg <= 1'b0;
      ready_out_reg    <= 1'b0;
      active_out_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      sym_reg          <= sym_next;
      sync_cnt_reg     <= sync_cnt_next;
      data_out_reg     <= data_out_next;
      symbol_start_reg <= symbol_start_next;
      ready_out_reg    <= ready_out_next;
      active_out_reg   <= active_out_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    sym_next          = sym_reg;
    sync_cnt_next     = sync_cnt_reg;
    active_out_next   = active_out_reg;
    cnt_next          = cnt_reg + 3'd1;
    data_out_next     = sym_reg[3'd7 - cnt_reg];
    symbol_start_next = (cnt_reg == 3'd0);

    // The last sync slot already behaves like ACTIVE: it offers a byte slot.
    load_active    = (state_reg == ACTIVE) || (sync_cnt_reg == SYNC_LAST);
    // Registered, so raising it at cnt==6 makes it visible during the cnt==7 cycle.
    ready_out_next = (cnt_reg == 3'd6) && load_active;

    if (cnt_reg == 3'd7) begin
      if (load_active) begin
        state_next      = ACTIVE;
        active_out_next = 1'b1;
        sym_next        = bus.valid_in ? bus.data_input : IDLE_CHAR;
      end else begin
        sym_next      = IDLE_CHAR;
        sync_cnt_next = sync_cnt_reg + 4'd1;
      end
    end
  end

  assign bus.data_out     = data_out_reg;
  assign bus.symbol_start = symbol_start_reg;
  assign bus.ready_out    = ready_out_reg;
  assign bus.active_out   = active_out_reg;

endmodule

// File: tb/tb_paralelo_serial.sv
// Randomised bench for paralelo_serial with SYNC_COUNT=4 and SYNC_COUNT=1 side by side,
// checked against an edge-index model of the transmitted symbol stream.
module tb_paralelo_serial;

  localparam logic [7:0] IDLE = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_drv = 8'h00;
  logic       valid_drv = 1'b0;

  int total = 0;
  int bad = 0;

  // Edges since reset release, reset flag of the last edge, and the symbol chosen per slot.
  int         n = 0;
  logic       rst_edge = 1'b1;
  logic [7:0] slot [512];

  paralelo_serial_if bus4 ();
  paralelo_serial_if bus1 ();

  assign bus4.data_input = data_drv;
  assign bus4.valid_in   = valid_drv;
  assign bus1.data_input = data_drv;
  assign bus1.valid_in   = valid_drv;

  paralelo_serial #(.SYNC_COUNT(4), .IDLE_CHAR(8'hBC)) dut4 (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus4.slave)
  );

  paralelo_serial #(.SYNC_COUNT(1), .IDLE_CHAR(8'hBC)) dut1 (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus1.slave)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  task automatic check_dut(input string name, input int sc, input logic d, input logic ss,
                           input logic rdy, input logic act);
    int s, b;
    logic [7:0] sym;
    if (rst_edge) begin
      chk({name, ".data_rst"}, {7'd0, d}, 8'd0);
      chk({name, ".ss_rst"}, {7'd0, ss}, 8'd0);
      chk({name, ".ready_rst"}, {7'd0, rdy}, 8'd0);
      chk({name, ".active_rst"}, {7'd0, act}, 8'd0);
    end else begin
      s   = (n - 1) / 8;
      b   = (n - 1) % 8;
      sym = (s < sc) ? IDLE : slot[s];
      chk({name, ".data"}, {7'd0, d}, {7'd0, sym[7 - b]});
      chk({name, ".ss"}, {7'd0, ss}, {7'd0, (b == 0)});
      chk({name, ".ready"}, {7'd0, rdy}, {7'd0, (n % 8 == 7) && (n >= 8 * sc - 1)});
      chk({name, ".active"}, {7'd0, act}, {7'd0, (n >= 8 * sc)});
    end
  endtask

  // One clock edge: update the model with the inputs present at the edge, then check.
  task automatic do_edge();
    @(posedge clk_32f);
    if (reset) begin
      n = 0;
      rst_edge = 1'b1;
    end else begin
      n++;
      rst_edge = 1'b0;
      if (n % 8 == 0) slot[n / 8] = valid_drv ? data_drv : IDLE;
    end
    #1;
    check_dut("sc4", 4, bus4.data_out, bus4.symbol_start, bus4.ready_out, bus4.active_out);
    check_dut("sc1", 1, bus1.data_out, bus1.symbol_start, bus1.ready_out, bus1.active_out);
    $display("edge n=%0d rst=%0b v=%0b d=%0h | sc4 do=%0b ss=%0b rdy=%0b act=%0b | sc1 do=%0b ss=%0b rdy=%0b act=%0b",
             n, rst_edge, valid_drv, data_drv,
             bus4.data_out, bus4.symbol_start, bus4.ready_out, bus4.active_out,
             bus1.data_out, bus1.symbol_start, bus1.ready_out, bus1.active_out);
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 5))
      0: return 8'hA5;
      1: return 8'hBC;
      2: return 8'h01;
      3: return 8'hFF;
      4: return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic drive_random(input int pct_valid);
    valid_drv = ($urandom_range(0, 99) < pct_valid);
    data_drv  = pick_byte();
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) do_edge();

    // Plain sync with no traffic; A5 offered at the first byte slot (accept edge 32).
    reset = 1'b0;
    valid_drv = 1'b0;
    for (int i = 0; i < 31; i++) do_edge();
    valid_drv = 1'b1;
    data_drv  = 8'hA5;
    do_edge();
    for (int i = 0; i < 11; i++) begin
      drive_random(50);
      do_edge();
    end

    // Mid-symbol reset at edge 44.
    reset = 1'b1;
    do_edge();
    reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      drive_random((i < 200) ? 85 : 30);
      do_edge();
    end

    reset = 1'b1;
    for (int i = 0; i < 3; i++) do_edge();
    reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      drive_random(60);
      do_edge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
